frame_buffer_ctrl: RTL and testbench

Parametrised, double-buffered frame-buffer controller for the display path: pixel store of FB_W×FB_H entries, PIX_BITS each, held as two pages in one inferred block RAM. The CPU writes and the hardware fill engine write the back page. The scan-out path reads the front page with fixed one-cycle latency. Pages swap only at a frame boundary, so the visible frame never tears.

---
 rtl/frame_buffer_ctrl.sv | 163 ++++++++++++++++
 tb/tb_frame_buffer_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// frame_buffer_ctrl
//
// Double-buffered frame store for the display path. Two pages of N = FB_W*FB_H
// pixels live in one block RAM (page p at addresses p*N .. p*N+N-1). The CPU
// and the fill engine write the back page. Scan-out reads the front page with
// one cycle of latency. Pages swap only on frame_start, so the visible frame
// never tears.
//
// Ports:
//   clk, reset       single clock, synchronous active-high reset
//   cpu_wr_*         CPU pixel write (valid/ready); out-of-range indices dropped
//   fill_start/...   fill the whole back page with fill_color; busy/done status
//   flip_req         request a page swap, applied at the next qualifying frame_start
//   frame_start      vertical-blank pulse from the display timing
//   flip_pending     a swap is requested but not yet applied
//   front_page       page currently scanned out
//   rd_en/rd_addr    scan-out read of the front page; rd_data one cycle later
// -----------------------------------------------------------------------------
module frame_buffer_ctrl #(
    parameter int FB_W     = 320,
    parameter int FB_H     = 240,
    parameter int PIX_BITS = 12,
    localparam int N       = FB_W * FB_H,
    localparam int AW      = $clog2(N)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_wr_valid,
    output logic                cpu_wr_ready,
    input  logic [AW-1:0]       cpu_wr_addr,
    input  logic [PIX_BITS-1:0] cpu_wr_data,
    input  logic                fill_start,
    input  logic [PIX_BITS-1:0] fill_color,
    output logic                fill_busy,
    output logic                fill_done,
    input  logic                flip_req,
    input  logic                frame_start,
    output logic                flip_pending,
    output logic                front_page,
    input  logic                rd_en,
    input  logic [AW-1:0]       rd_addr,
    output logic [PIX_BITS-1:0] rd_data
);

    localparam int RAW = $clog2(2 * N);
    localparam logic [AW:0]     N_EXT      = (AW + 1)'(N);
    localparam logic [AW-1:0]   LAST_IDX   = AW'(N - 1);
    localparam logic [RAW-1:0]  PAGE1_BASE = RAW'(N);

    typedef enum logic {IDLE, FILL} fill_state_t;

    fill_state_t         state;
    logic [AW-1:0]       cnt;
    logic [PIX_BITS-1:0] color;

    logic [PIX_BITS-1:0] mem [2*N];

    logic                back_page;
    logic                cpu_accept;
    logic                cpu_in_range;
    logic                wr_en;
    logic [RAW-1:0]      wr_addr;
    logic [PIX_BITS-1:0] wr_data;

    // Page base is p*N; N need not be a power of two, so add rather than concatenate.
    function automatic logic [RAW-1:0] ram_addr(input logic page, input logic [AW-1:0] idx);
        return (page ? PAGE1_BASE : '0) + RAW'(idx);
    endfunction

    assign back_page    = ~front_page;
    assign cpu_wr_ready = ~fill_busy;
    assign cpu_accept   = cpu_wr_valid & cpu_wr_ready;
    assign cpu_in_range = {1'b0, cpu_wr_addr} < N_EXT;

    // Single write port. The fill engine owns it while busy; the CPU is held off
    // by cpu_wr_ready, so the two never compete. Out-of-range CPU indices are
    // accepted but never reach the RAM, so they cannot alias into the other page.
    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (fill_busy) begin
            wr_en   = 1'b1;
            wr_addr = ram_addr(back_page, cnt);
            wr_data = color;
        end else if (cpu_accept && cpu_in_range) begin
            wr_en   = 1'b1;
            wr_addr = ram_addr(back_page, cpu_wr_addr);
            wr_data = cpu_wr_data;
        end
    end

    // Fill engine: one pixel per cycle, fill_done pulses as fill_busy falls.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            color     <= '0;
            fill_busy <= 1'b0;
            fill_done <= 1'b0;
        end else begin
            fill_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (fill_start) begin
                        color     <= fill_color;
                        cnt       <= '0;
                        state     <= FILL;
                        fill_busy <= 1'b1;
                    end
                end
                FILL: begin
                    if (cnt == LAST_IDX) begin
                        state     <= IDLE;
                        fill_busy <= 1'b0;
                        fill_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    fill_busy <= 1'b0;
                end
            endcase
        end
    end

    // Page swap. A flip_req coinciding with frame_start counts immediately.
    // While a fill runs the swap is held off so the fill never lands on the
    // page being scanned out.
    always_ff @(posedge clk) begin
        if (reset) begin
            front_page   <= 1'b0;
            flip_pending <= 1'b0;
        end else if (frame_start && (flip_pending || flip_req) && !fill_busy) begin
            front_page   <= ~front_page;
            flip_pending <= 1'b0;
        end else if (flip_req) begin
            flip_pending <= 1'b1;
        end
    end

    // NOTE: the pixel array has no reset so it maps onto block RAM; clear it with a fill.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read of the front page; holds its value while rd_en is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[ram_addr(front_page, rd_addr)];
        end
    end

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frame_buffer_ctrl
//
// Self-checking bench for frame_buffer_ctrl. The main instance uses a 4x2
// frame (N=8). A pixel model tracks both pages; each read pushes the model's
// value for the current front page onto a scoreboard queue, popped and compared
// when rd_data becomes valid. With N=8 the 3-bit index cannot express an
// out-of-range address, so a second 3x2 instance (N=6, 3-bit index) covers
// dropped out-of-range writes.
// -----------------------------------------------------------------------------
module tb_frame_buffer_ctrl;

    localparam int W = 4;
    localparam int H = 2;
    localparam int N = W * H;

    logic        clk;
    logic        reset;
    logic        cpu_wr_valid;
    logic        cpu_wr_ready;
    logic [2:0]  cpu_wr_addr;
    logic [11:0] cpu_wr_data;
    logic        fill_start;
    logic [11:0] fill_color;
    logic        fill_busy;
    logic        fill_done;
    logic        flip_req;
    logic        frame_start;
    logic        flip_pending;
    logic        front_page;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [11:0] rd_data;

    // Out-of-range instance (N=6).
    logic        o_cpu_wr_valid;
    logic        o_cpu_wr_ready;
    logic [2:0]  o_cpu_wr_addr;
    logic [11:0] o_cpu_wr_data;
    logic        o_fill_start;
    logic [11:0] o_fill_color;
    logic        o_fill_busy;
    logic        o_fill_done;
    logic        o_flip_req;
    logic        o_frame_start;
    logic        o_flip_pending;
    logic        o_front_page;
    logic        o_rd_en;
    logic [2:0]  o_rd_addr;
    logic [11:0] o_rd_data;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] model [2][N];
    logic        exp_front;
    logic [11:0] sb [$];

    frame_buffer_ctrl #(.FB_W(W), .FB_H(H), .PIX_BITS(12)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_wr_valid (cpu_wr_valid),
        .cpu_wr_ready (cpu_wr_ready),
        .cpu_wr_addr  (cpu_wr_addr),
        .cpu_wr_data  (cpu_wr_data),
        .fill_start   (fill_start),
        .fill_color   (fill_color),
        .fill_busy    (fill_busy),
        .fill_done    (fill_done),
        .flip_req     (flip_req),
        .frame_start  (frame_start),
        .flip_pending (flip_pending),
        .front_page   (front_page),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data)
    );

    frame_buffer_ctrl #(.FB_W(3), .FB_H(2), .PIX_BITS(12)) dut_oor (
        .clk          (clk),
        .reset        (reset),
        .cpu_wr_valid (o_cpu_wr_valid),
        .cpu_wr_ready (o_cpu_wr_ready),
        .cpu_wr_addr  (o_cpu_wr_addr),
        .cpu_wr_data  (o_cpu_wr_data),
        .fill_start   (o_fill_start),
        .fill_color   (o_fill_color),
        .fill_busy    (o_fill_busy),
        .fill_done    (o_fill_done),
        .flip_req     (o_flip_req),
        .frame_start  (o_frame_start),
        .flip_pending (o_flip_pending),
        .front_page   (o_front_page),
        .rd_en        (o_rd_en),
        .rd_addr      (o_rd_addr),
        .rd_data      (o_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle, drop all one-cycle pulses, and retire a pending read.
    task automatic tick();
        logic        was_rd;
        logic [11:0] exp;
        was_rd = rd_en;
        @(posedge clk);
        #1;
        cpu_wr_valid   = 1'b0;
        fill_start     = 1'b0;
        flip_req       = 1'b0;
        frame_start    = 1'b0;
        rd_en          = 1'b0;
        o_cpu_wr_valid = 1'b0;
        o_fill_start   = 1'b0;
        o_flip_req     = 1'b0;
        o_frame_start  = 1'b0;
        o_rd_en        = 1'b0;
        if (was_rd) begin
            exp = sb.pop_front();
            check("rd_data", rd_data, exp);
        end
    endtask

    task automatic issue_read(input int addr);
        rd_en   = 1'b1;
        rd_addr = 3'(addr);
        sb.push_back(model[exp_front][addr]);
    endtask

    task automatic read_all();
        for (int i = 0; i < N; i++) begin
            issue_read(i);
            tick();
        end
    endtask

    task automatic cpu_write(input int addr, input logic [11:0] data);
        cpu_wr_valid = 1'b1;
        cpu_wr_addr  = 3'(addr);
        cpu_wr_data  = data;
        check("cpu_wr_ready", cpu_wr_ready, 1);
        model[~exp_front][addr] = data;
        tick();
    endtask

    task automatic flip_now();
        flip_req    = 1'b1;
        frame_start = 1'b1;
        tick();
        exp_front = ~exp_front;
        check("front_page_flip", front_page, exp_front);
        check("flip_pending_clr", flip_pending, 0);
    endtask

    // Start a fill (optionally with a coincident CPU write that the fill must
    // overwrite) and observe a fixed window of cycles.
    task automatic run_fill(input logic [11:0] color, input bit with_cpu);
        int busy_n, done_n, ready_bad, fall_c, done_c;
        busy_n = 0; done_n = 0; ready_bad = 0; fall_c = -1; done_c = -1;
        fill_color = color;
        fill_start = 1'b1;
        if (with_cpu) begin
            cpu_wr_valid = 1'b1;
            cpu_wr_addr  = 3'd5;
            cpu_wr_data  = 12'h777;
        end
        tick();
        check("fill_busy_rise", fill_busy, 1);
        for (int c = 0; c < N + 4; c++) begin
            if (fill_busy) busy_n++;
            if (fill_busy && cpu_wr_ready) ready_bad++;
            if (fill_done) begin
                done_n++;
                done_c = c;
            end
            if (!fill_busy && fall_c < 0) fall_c = c;
            tick();
        end
        check("fill_busy_cycles", busy_n, N);
        check("ready_low_in_fill", ready_bad, 0);
        check("fill_done_pulses", done_n, 1);
        check("fill_done_at_fall", done_c, fall_c);
        for (int i = 0; i < N; i++) model[~exp_front][i] = color;
    endtask

    task automatic o_fill(input logic [11:0] color);
        o_fill_color = color;
        o_fill_start = 1'b1;
        tick();
        repeat (7) tick();
        check("oor_fill_idle", o_fill_busy, 0);
    endtask

    task automatic o_flip();
        o_flip_req    = 1'b1;
        o_frame_start = 1'b1;
        tick();
    endtask

    task automatic o_read(input int addr, input logic [11:0] exp);
        o_rd_en   = 1'b1;
        o_rd_addr = 3'(addr);
        tick();
        check("oor_rd_data", o_rd_data, exp);
    endtask

    initial begin
        int waited;
        int late_done;
        reset = 1'b1;
        cpu_wr_valid = 0; cpu_wr_addr = 0; cpu_wr_data = 0;
        fill_start = 0; fill_color = 0; flip_req = 0; frame_start = 0;
        rd_en = 0; rd_addr = 0;
        o_cpu_wr_valid = 0; o_cpu_wr_addr = 0; o_cpu_wr_data = 0;
        o_fill_start = 0; o_fill_color = 0; o_flip_req = 0; o_frame_start = 0;
        o_rd_en = 0; o_rd_addr = 0;
        exp_front = 1'b0;

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        check("rst_front_page", front_page, 0);
        check("rst_flip_pending", flip_pending, 0);
        check("rst_fill_busy", fill_busy, 0);
        check("rst_fill_done", fill_done, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_cpu_wr_ready", cpu_wr_ready, 1);

        // CPU write, frame_start with no request, then request + frame_start
        cpu_write(3, 12'hABC);
        frame_start = 1'b1;
        tick();
        check("nf_front_page", front_page, 0);
        check("nf_flip_pending", flip_pending, 0);
        flip_req = 1'b1;
        tick();
        check("req_pending", flip_pending, 1);
        check("req_no_flip_yet", front_page, 0);
        frame_start = 1'b1;
        tick();
        exp_front = 1'b1;
        check("flip_front_page", front_page, 1);
        check("flip_pending_clr", flip_pending, 0);
        issue_read(3);
        tick();

        // Fill with a coincident CPU write, flip, read the whole page
        run_fill(12'h0F0, 1'b1);
        flip_now();
        read_all();

        // Flip requested during a fill is deferred past a busy frame_start
        fill_color = 12'h00F;
        fill_start = 1'b1;
        tick();
        flip_req = 1'b1;
        tick();
        check("dfr_pending_set", flip_pending, 1);
        flip_req = 1'b1;
        tick();
        frame_start = 1'b1;
        tick();
        check("dfr_no_flip", front_page, exp_front);
        check("dfr_still_pending", flip_pending, 1);
        waited = 0;
        while (fill_busy && waited < 20) begin
            tick();
            waited++;
        end
        check("dfr_fill_ended", fill_busy, 0);
        for (int i = 0; i < N; i++) model[~exp_front][i] = 12'h00F;
        frame_start = 1'b1;
        tick();
        exp_front = ~exp_front;
        check("dfr_flip_front", front_page, exp_front);
        check("dfr_pending_clr", flip_pending, 0);
        frame_start = 1'b1;
        tick();
        check("dfr_no_double_flip", front_page, exp_front);
        issue_read(2);
        tick();

        // Same-cycle flip_req + frame_start; a read in that cycle sees the old page
        issue_read(3);
        flip_req    = 1'b1;
        frame_start = 1'b1;
        tick();
        exp_front = ~exp_front;
        check("same_cycle_flip", front_page, exp_front);
        issue_read(3);
        tick();

        // Reset on the 4th fill cycle aborts the fill and drops a pending flip
        fill_color = 12'h3C3;
        fill_start = 1'b1;
        tick();
        flip_req = 1'b1;
        tick();
        tick();
        check("abort_pending_set", flip_pending, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_front = 1'b0;
        check("abort_fill_busy", fill_busy, 0);
        check("abort_fill_done", fill_done, 0);
        check("abort_front_page", front_page, 0);
        check("abort_pending_drop", flip_pending, 0);
        late_done = 0;
        for (int c = 0; c < 12; c++) begin
            if (fill_done || fill_busy) late_done++;
            tick();
        end
        check("abort_no_late_done", late_done, 0);
        run_fill(12'h555, 1'b0);
        flip_now();
        read_all();

        // Out-of-range CPU writes on the N=6 instance must be dropped
        o_fill(12'h111);
        o_flip();
        check("oor_front", o_front_page, 1);
        o_fill(12'h222);
        for (int a = 6; a < 8; a++) begin
            o_cpu_wr_valid = 1'b1;
            o_cpu_wr_addr  = 3'(a);
            o_cpu_wr_data  = 12'h123;
            check("oor_wr_ready", o_cpu_wr_ready, 1);
            tick();
        end
        for (int i = 0; i < 6; i++) o_read(i, 12'h111);
        o_flip();
        check("oor_front_back", o_front_page, 0);
        for (int i = 0; i < 6; i++) o_read(i, 12'h222);

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
